// File: rtl/meter_display_if.sv
// meter_display_if: bundles the meter-to-display signals.
//   time_left : remaining seconds from the meter (binary, 14 bits)
//   sec_tick  : one-cycle pulse at each 1 s decrement
//   an        : digit anodes, active-low one-hot, an[0] = ones digit
//   seg       : segments {g,f,e,d,c,b,a}, active-low
//   busy      : high while a BCD conversion is running
// master = meter side, slave = display side.
interface meter_display_if;
    logic [13:0] time_left;
    logic        sec_tick;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        busy;

    modport master (output time_left, sec_tick, input an, seg, busy);
    modport slave  (input time_left, sec_tick, output an, seg, busy);
endinterface

// File: rtl/meter_display.sv
// meter_display: 4-digit common-anode 7-segment driver for the parking meter.
// Clamps time_left to 9999, converts it to BCD with a 14-cycle shift-add-3
// engine, multiplexes the digits and applies the blink rules
// (0 -> 1 Hz flash, 1..179 -> 1 s on / 1 s off, >=180 -> steady).
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : meter_display_if.slave (time_left, sec_tick in; an, seg, busy out)
// Parameters:
//   CLK_HZ   : clk cycles per second (blink phase)
//   SCAN_DIV : clk cycles each digit stays selected (>=1)
// Optional macro LEADING_ZERO_BLANK_EN: leading zero digits above the ones
// digit show blank segments while their anode stays driven.
module meter_display #(
    parameter int CLK_HZ   = 100,
    parameter int SCAN_DIV = 1
) (
    input  logic            clk,
    input  logic            rst,
    meter_display_if.slave  bus
);
    localparam int PW = $clog2(CLK_HZ + 1);
    localparam int DW = $clog2(SCAN_DIV + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_nx;
    logic [13:0]   val, last_val, sh;
    logic [15:0]   acc, adj, acc_nx, bcd;
    logic [3:0]    cnt;
    logic          busy_r;
    logic [PW-1:0] ph_cnt;
    logic          sec_par;
    logic [DW-1:0] div;
    logic [1:0]    idx;
    logic [3:0]    dig;
    logic          blank, lead;
    logic [3:0]    an_r;
    logic [6:0]    seg_r;

    assign val      = (bus.time_left > 14'd9999) ? 14'd9999 : bus.time_left;
    assign bus.busy = busy_r;
    assign bus.an   = an_r;
    assign bus.seg  = seg_r;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Add-3 on every digit >=5, then shift the next binary bit in.
    always_comb begin
        adj = acc;
        for (int i = 0; i < 4; i++)
            if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        acc_nx = {adj[14:0], sh[13]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (val != last_val) state_nx = SHIFT;
            SHIFT:   if (cnt == 4'd13)    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Conversion datapath; bcd only changes on the final shift, so the
    // display never sees a partial result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh <= '0; acc <= '0; bcd <= '0; last_val <= '0; cnt <= '0; busy_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (val != last_val) begin
                    sh       <= val;
                    last_val <= val;
                    acc      <= '0;
                    cnt      <= '0;
                    busy_r   <= 1'b1;
                end
                SHIFT: begin
                    acc <= acc_nx;
                    sh  <= {sh[12:0], 1'b0};
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd13) begin
                        bcd    <= acc_nx;
                        busy_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Blink phase; sec_tick resynchronises the second to the meter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph_cnt  <= '0;
            sec_par <= 1'b0;
        end else if (bus.sec_tick) begin
            ph_cnt  <= '0;
            sec_par <= ~sec_par;
        end else if (ph_cnt == PW'(CLK_HZ - 1)) begin
            ph_cnt  <= '0;
            sec_par <= ~sec_par;
        end else begin
            ph_cnt  <= ph_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
            idx <= '0;
        end else if (div == DW'(SCAN_DIV - 1)) begin
            div <= '0;
            idx <= idx + 2'd1;
        end else begin
            div <= div + 1'b1;
        end
    end

    // BCD order matches numeric order, so 0180 can be compared directly.
    assign blank = (bcd == 16'h0000) ? (ph_cnt >= PW'(CLK_HZ / 2)) :
                   (bcd <  16'h0180) ? sec_par : 1'b0;
    assign dig   = bcd[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    assign lead = ((idx == 2'd3) && (bcd[15:12] == 4'd0)) ||
                  ((idx == 2'd2) && (bcd[15:8]  == 8'd0)) ||
                  ((idx == 2'd1) && (bcd[15:4]  == 12'd0));
`else
    assign lead = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_r  <= 4'hF;
            seg_r <= 7'h7F;
        end else if (blank) begin
            an_r  <= 4'hF;
            seg_r <= 7'h7F;
        end else begin
            an_r  <= ~(4'b0001 << idx);
            seg_r <= lead ? 7'h7F : seg7(dig);
        end
    end
endmodule

// File: doc/meter_display.md
Name: meter_display

Overview:
- Downstream of parking_meter: consumes the remaining-time count and drives the 4-digit common-anode seven-segment display.
- Converts the binary time to BCD with a sequential shift-add-3 engine and time-multiplexes the digits.
- Applies the meter's blink rules: flash at zero, slow blink below 180 s, steady otherwise.

Parameters:
- CLK_HZ, 100, clk cycles per second; sets the internal half-second and second phase.
- SCAN_DIV, 1, clk cycles each digit stays selected before the scan advances (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- time_left  in  14  remaining seconds from meter, binary, 0..16383
- sec_tick  in  1  one-cycle pulse from meter at each 1 s decrement
- an  out  4  digit anodes, active-low, one-hot; an[0] = ones digit
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- busy  out  1  high while a BCD conversion is in progress

Behaviour:
- Reset (rst=0, async):
  - an=4'hF, seg=7'h7F, busy=0.
  - bcd digits=0, last_val=0, state=IDLE, ph_cnt=0, sec_par=0, digit index=0.
- Clamp: val = (time_left>9999) ? 9999 : time_left. Clamping is combinational, ahead of all logic.
- Conversion FSM: IDLE -> SHIFT -> IDLE.
  - IDLE: when val != last_val, latch val into the shift register and into last_val, clear the BCD accumulator, set busy, enter SHIFT.
  - SHIFT: 14 cycles of add-3 (digits ≥5) followed by a left shift.
  - On the 14th SHIFT edge: commit the accumulator to the displayed bcd register, clear busy, return to IDLE.
  - Latency: bcd is updated 15 clk edges after the edge where the change is first sampled.
  - A time_left change during SHIFT is ignored until IDLE; the latest val is then converted (no loss of the final value).
  - Display always shows the last committed bcd; no partial values are shown.
- Phase:
  - ph_cnt counts 0..CLK_HZ-1 and wraps; each wrap toggles sec_par.
  - sec_tick forces ph_cnt=0 and toggles sec_par, taking priority over the wrap in the same cycle.
- Blank rule (evaluated on committed bcd):
  - bcd==0000: blank while ph_cnt ≥ CLK_HZ/2, giving a 1 Hz, 50 % flash.
  - 0001..0179: blank while sec_par==1, giving 1 s on / 1 s off.
  - ≥0180: never blank.
- Scan:
  - The digit index advances 0→1→2→3→0 every SCAN_DIV cycles.
  - an/seg are registered, 1 cycle behind the index.
  - When blanked: an=4'hF, seg=7'h7F.
- Encoding (active-low gfedcba): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex). Leading zeros are shown.
- Reset mid-conversion aborts immediately; the display returns to the "0000" flash.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: leading zero digits above the ones digit show seg=7'h7F while their anode is still driven. Example: 15 displays as "  15"; 0 displays as "   0" and still flashes.
- Undefined: all four digits are always shown, e.g. "0015".

Test Plan:
- Release rst with time_left=0, sec_tick idle, CLK_HZ=100 -> busy stays 0; digits show seg=40 for cycles 0..49 of each 100-cycle period and an=F for cycles 50..99.
- time_left 0→300 -> busy high for exactly 14 cycles; bcd=0300 after 15 edges; display steady with digits 0,0,3,0 (seg 40,40,30,40 for an[0..3]).
- time_left=195, then pulse sec_tick each 100 cycles while decrementing -> steady at 181 and 180; at 179 alternate seconds blank (an=F for the whole second when sec_par=1).
- time_left=16383 -> clamped; shows 9999 (all seg=10); busy pulse of 14 cycles.
- Change time_left 60→120→180 on consecutive cycles while busy -> final committed bcd=0180 with no intermediate glitch to other values; two conversions total.
- Assert rst during SHIFT (cycle 5) -> an=F, seg=7F, busy=0 asynchronously; after release the display shows the "0000" flash.
